soc_system_flags_capture: RTL and testbench

SOC_SYSTEM_FLAGS_CAPTURE -- requirements
Module: soc_system_flags_capture

---
 rtl/soc_system_flags_capture.sv | 154 +++++++++++++++
 tb/tb_soc_system_flags_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/soc_system_flags_capture.sv
// ---------------------------------------------------------------------------
// soc_system_flags_capture
//
// Captures edges on a bank of asynchronous external flag inputs and presents
// them through a small Avalon-MM slave with a level interrupt.
//
// Each in_port bit is synchronised, optionally debounced, and edge-detected.
// Detected edges set sticky EDGECAP bits that software clears by writing 1s.
// irq is the OR of EDGECAP bits enabled in IRQMASK.
//
// Register map (word address):
//   0 DATA    RO  current flag value, zero-extended
//   1 IRQMASK RW  WIDTH-bit interrupt enable
//   2 -       reads 0, writes ignored
//   3 EDGECAP W1C sticky edge capture (a new edge beats a same-cycle clear)
//
// Bus handshake: there is no wait-state or read strobe. A write takes effect
// at the clk edge where chipselect=1 and write_n=0. readdata is registered
// every clk from the current address, so it is valid one cycle after the
// address is applied, and reads have no side effects.
//
// Optional feature: define SOC_SYSTEM_FLAGS_DEBOUNCE_EN to add a per-bit
// debounce filter of DEBOUNCE_CYCLES samples between the synchroniser and
// the edge detector.
//
// Ports:
//   clk        single clock
//   reset_n    asynchronous active-low reset
//   address    word address (2 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   in_port    WIDTH asynchronous external flags
//   readdata   32-bit registered read data
//   irq        active-high level interrupt
// ---------------------------------------------------------------------------
module soc_system_flags_capture #(
    parameter int WIDTH           = 32,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] flag_val;
    logic [WIDTH-1:0] flag_prev;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             wr;

    assign wr = chipselect & ~write_n;

    // Synchroniser chain; all stages reset to 0 so a low input after reset
    // release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef SOC_SYSTEM_FLAGS_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    deb_cnt [WIDTH];
    logic [WIDTH-1:0] deb_val;

    // The counter measures how long sync_val has disagreed with the
    // debounced value; any return to agreement restarts it, so only a level
    // held for DEBOUNCE_CYCLES samples is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
            deb_val <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_val[i] == deb_val[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_val[i] <= sync_val[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign flag_val = deb_val;
`else
    assign flag_val = sync_val;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flag_prev <= '0;
        else          flag_prev <= flag_val;
    end

    always_comb begin
        edge_vec = '0;
        case (EDGE_TYPE)
            0:       edge_vec = flag_val & ~flag_prev;
            1:       edge_vec = ~flag_val & flag_prev;
            default: edge_vec = flag_val ^ flag_prev;
        endcase
    end

    // Register file. In EDGECAP the clear is applied first and the new edge
    // OR'd in after it, so a same-cycle edge keeps its bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr && address == 2'd1) irqmask <= writedata[WIDTH-1:0];
            if (wr && address == 2'd3)
                edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | edge_vec;
            else
                edgecap <= edgecap | edge_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(flag_val);
                2'd1:    readdata <= 32'(irqmask);
                2'd3:    readdata <= 32'(edgecap);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_system_flags_capture.sv
module tb_soc_system_flags_capture;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
`ifdef SOC_SYSTEM_FLAGS_DEBOUNCE_EN
    localparam int DEB = 4;
    localparam int LAT = SYNC + 1 + DEB;
`else
    localparam int DEB = 4;
    localparam int LAT = SYNC + 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0;
    int errors = 0;

    soc_system_flags_capture #(
        .WIDTH(WIDTH), .EDGE_TYPE(0), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // driver tasks: all driving and sampling happens 1 time unit after posedge
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        tick(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(2);
        bus_read(2'd3);
        check("no_spurious_edge", readdata, 32'h0);

        // DATA read
        in_port = 8'hA5;
        address = 2'd0;
        tick(LAT + 2);
        check("data_a5", readdata, 32'h0000_00A5);
        check("irq_unmasked", {31'b0, irq}, 32'h0);
        in_port = 8'h00;
        tick(LAT + 2);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3);
        check("edgecap_cleared", readdata, 32'h0);

        // reserved address and mask width
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        check("reserved_reads_0", readdata, 32'h0);
        bus_write(2'd1, 32'hFFFF_FF01);
        bus_read(2'd1);
        check("irqmask_width", readdata, 32'h0000_0001);

        // rising capture and irq, latency LAT
        in_port = 8'h01;
        tick(LAT - 1);
        check("irq_before_lat", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_at_lat", {31'b0, irq}, 32'h1);
        bus_read(2'd3);
        check("edgecap_bit0", readdata, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_after_clear", {31'b0, irq}, 32'h0);

        // masked edge on bit 3
        bus_write(2'd1, 32'h0);
        in_port = 8'h09;
        tick(LAT + 1);
        bus_read(2'd3);
        check("edgecap_bit3", readdata, 32'h08);
        check("irq_masked", {31'b0, irq}, 32'h0);
        bus_write(2'd1, 32'h08);
        check("irq_unmask", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h08);
        check("irq_clear_bit3", {31'b0, irq}, 32'h0);

        // simultaneous set and clear on bit 2
        in_port = 8'h0D;
        tick(LAT - 1);
        bus_write(2'd3, 32'h04);
        bus_read(2'd3);
        check("set_wins", readdata, 32'h04);
        bus_write(2'd3, 32'h04);
        bus_read(2'd3);
        check("clear_no_edge", readdata, 32'h0);

        // falling edges are not captured with rising EDGE_TYPE
        in_port = 8'h00;
        tick(LAT + 2);
        bus_read(2'd3);
        check("falling_ignored", readdata, 32'h0);

`ifdef SOC_SYSTEM_FLAGS_DEBOUNCE_EN
        // glitch rejected, held level accepted
        in_port = 8'h02;
        tick(2);
        in_port = 8'h00;
        tick(10);
        bus_read(2'd0);
        check("glitch_data", readdata, 32'h0);
        bus_read(2'd3);
        check("glitch_cap", readdata, 32'h0);
        in_port = 8'h02;
        tick(10);
        bus_read(2'd0);
        check("held_data", readdata, 32'h02);
        bus_read(2'd3);
        check("held_cap", readdata, 32'h02);
        in_port = 8'h00;
        tick(LAT + 2);
        bus_write(2'd3, 32'hFF);
`endif

        // reset mid-operation
        bus_write(2'd1, 32'hFF);
        in_port = 8'hFF;
        tick(LAT + 1);
        bus_read(2'd3);
        check("edgecap_ff", readdata, 32'hFF);
        check("irq_ff", {31'b0, irq}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'b0, irq}, 32'h0);
        check("async_readdata", readdata, 32'h0);
        in_port = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        tick(LAT + 1);
        bus_read(2'd0);
        check("post_rst_data", readdata, 32'h0);
        bus_read(2'd1);
        check("post_rst_mask", readdata, 32'h0);
        bus_read(2'd2);
        check("post_rst_resv", readdata, 32'h0);
        bus_read(2'd3);
        check("post_rst_cap", readdata, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
